nibble_serial_sub: RTL

- Multi-cycle subtractor that computes D = A - B - Bin one 4-bit slice per clock, LSB nibble first.
- Each slice uses a 4-bit borrow-lookahead stage: subtract as A + ~B + ~Bin, with generate/propagate carry lookahead, and borrow = ~carry.
- The borrow is registered between nibbles.
- Sits beside the combinational adder slices in the lab ALU datapath as the area-lean subtract path, under a start/busy/done handshake.

---
 rtl/nibble_serial_sub.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: D = A - B - Bin, one 4-bit borrow-lookahead slice per clock,
// LSB nibble first, with the inter-nibble borrow held in a register.
module nibble_serial_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 4-bit carry lookahead adder: returns {c4, sum[3:0]} of x + y + c0.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [3:0]         a_nib_s;
  logic [3:0]         b_nib_inv_s;
  logic [4:0]         slice_s;
  logic               last_s;

  // Current slice: A nibble plus inverted B nibble plus inverted borrow.
  always_comb begin
    a_nib_s     = a_q[{cnt_q, 2'b00} +: 4];
    b_nib_inv_s = ~b_q[{cnt_q, 2'b00} +: 4];
    slice_s     = cla4(a_nib_s, b_nib_inv_s, ~borrow_q);
    last_s      = (cnt_q == CNT_W'(NSLICE - 1));
  end

  // Next-state, datapath and result-flag logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = {CNT_W{1'b0}};
          res_d    = {WIDTH{1'b0}};
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        // Result nibbles enter at the top so the LSB nibble ends up at bit 0.
        res_d    = {slice_s[3:0], res_q[WIDTH-1:4]};
        borrow_d = ~slice_s[4];
        if (last_s) begin
          state_d = S_DONE;
          cnt_d   = {CNT_W{1'b0}};
          diff_d  = res_d;
          bout_d  = ~slice_s[4];
          zero_d  = (res_d == {WIDTH{1'b0}});
          neg_d   = res_d[WIDTH-1];
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res_d[WIDTH-1] ^ a_q[WIDTH-1]);
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      res_q    <= {WIDTH{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule
